// File: rtl/field_sram_port_if.sv
// Game-FSM side of the playfield SRAM port: buffered cell writes, cell reads
// for collision checks, and the whole-field clear handshake.
interface field_sram_port_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  wr_x;
    logic [4:0]  wr_y;
    logic [11:0] wr_color;
    logic        rd_req;
    logic [4:0]  rd_x;
    logic [4:0]  rd_y;
    logic        rd_busy;
    logic        rd_valid;
    logic [11:0] rd_color;
    logic        clr_start;
    logic        clr_done;

    // Game state machine side
    modport master (
        output wr_valid, wr_x, wr_y, wr_color, rd_req, rd_x, rd_y, clr_start,
        input  wr_ready, rd_busy, rd_valid, rd_color, clr_done
    );

    // SRAM port side
    modport slave (
        input  wr_valid, wr_x, wr_y, wr_color, rd_req, rd_x, rd_y, clr_start,
        output wr_ready, rd_busy, rd_valid, rd_color, clr_done
    );
endinterface

// File: rtl/field_sram_port.sv
// Sole owner of the playfield SRAM. The beam gets the bus inside the display
// window; cell writes (FIFO-buffered), cell reads and the clear engine share
// the remaining free slots, one 2-cycle operation at a time.
module field_sram_port #(
    parameter int FIFO_DEPTH = 4,
    parameter int FIELD_X0   = 220,
    parameter int FIELD_Y0   = 20,
    parameter int CELL_PX    = 20,
    parameter int COLS       = 10,
    parameter int ROWS       = 22
) (
    input  logic               VGA_CTRL_CLK,
    input  logic               RST,
    input  logic [9:0]         px,
    input  logic [9:0]         py,
    field_sram_port_if.slave   bus,
    output logic [11:0]        pix_color,
    output logic [17:0]        SRAM_ADDR,
    inout  wire  [15:0]        SRAM_DQ,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int XEND = FIELD_X0 + COLS * CELL_PX - 1;
    localparam int YEND = FIELD_Y0 + ROWS * CELL_PX - 1;

    typedef enum logic [2:0] {IDLE, WR_SETUP, WR_HOLD, RD, CLR_SETUP, CLR_HOLD} state_t;

    state_t      r_state, w_next;

    logic [21:0] r_fifo [FIFO_DEPTH];   // {x, y, color}
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0] r_count;

    logic        r_rd_busy, r_rd_valid;
    logic [4:0]  r_rd_x, r_rd_y;
    logic [11:0] r_rd_color;

    logic        r_clr_act, r_clr_done;
    logic [4:0]  r_cx, r_cy;

    logic [11:0] r_pix;

    logic        w_row_in, w_win, w_free;
    logic [9:0]  w_dx, w_dy;
    logic [4:0]  w_cx, w_cy;
    logic        w_wr_ready, w_push, w_pop, w_rd_new;
    logic [21:0] w_head;
    logic [17:0] w_addr;
    logic [15:0] w_wdata;
    logic        w_we_n, w_oe_n, w_drive;

    // Beam position: display window, and slots where a 2-cycle op can start
    // and still finish before the window's first column.
    assign w_row_in = (py >= 10'(FIELD_Y0)) && (py <= 10'(YEND));
    assign w_win    = w_row_in && (px >= 10'(FIELD_X0)) && (px <= 10'(XEND));
    assign w_free   = !w_row_in || (px < 10'(FIELD_X0 - 2)) || (px > 10'(XEND));
    assign w_dx     = px - 10'(FIELD_X0);
    assign w_dy     = py - 10'(FIELD_Y0);
    assign w_cx     = 5'(w_dx / 10'(CELL_PX));
    assign w_cy     = 5'(w_dy / 10'(CELL_PX));

    assign w_wr_ready = r_count < (AW+1)'(FIFO_DEPTH);
    assign w_push     = bus.wr_valid && w_wr_ready;
    assign w_pop      = (r_state == WR_HOLD);
    assign w_rd_new   = bus.rd_req && !r_rd_busy;
    assign w_head     = r_fifo[r_rptr];

    // FIFO storage needs no reset; pointers and count define validity
    always_ff @(posedge VGA_CTRL_CLK) begin
        if (w_push) r_fifo[r_wptr] <= {bus.wr_x, bus.wr_y, bus.wr_color};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge VGA_CTRL_CLK or negedge RST) begin
        if (!RST) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Read request latch and result capture at the end of the RD cycle
    always_ff @(posedge VGA_CTRL_CLK or negedge RST) begin
        if (!RST) begin
            r_rd_busy  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_x     <= '0;
            r_rd_y     <= '0;
            r_rd_color <= '0;
        end else if (r_state == RD) begin
            r_rd_busy  <= 1'b0;
            r_rd_valid <= 1'b1;
            r_rd_color <= SRAM_DQ[15:4];
        end else begin
            r_rd_valid <= 1'b0;
            if (w_rd_new) begin
                r_rd_busy <= 1'b1;
                r_rd_x    <= bus.rd_x;
                r_rd_y    <= bus.rd_y;
            end
        end
    end

    // Clear engine: walks (cx,cy) row-major, one cell per CLR_HOLD
    always_ff @(posedge VGA_CTRL_CLK or negedge RST) begin
        if (!RST) begin
            r_clr_act  <= 1'b0;
            r_clr_done <= 1'b0;
            r_cx       <= '0;
            r_cy       <= '0;
        end else begin
            r_clr_done <= 1'b0;
            if (r_state == CLR_HOLD) begin
                if (r_cx == 5'(COLS - 1)) begin
                    r_cx <= '0;
                    if (r_cy == 5'(ROWS - 1)) begin
                        r_clr_act  <= 1'b0;
                        r_clr_done <= 1'b1;
                    end else begin
                        r_cy <= r_cy + 1'b1;
                    end
                end else begin
                    r_cx <= r_cx + 1'b1;
                end
            end else if (bus.clr_start && !r_clr_act) begin
                r_clr_act <= 1'b1;
                r_cx      <= '0;
                r_cy      <= '0;
            end
        end
    end

    // State register
    always_ff @(posedge VGA_CTRL_CLK or negedge RST) begin
        if (!RST) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // Next state and SRAM strobes; IDLE hands the bus to the beam
    always_comb begin
        w_next  = r_state;
        w_addr  = {w_cx, w_cy, 8'b0};
        w_wdata = '0;
        w_we_n  = 1'b1;
        w_oe_n  = 1'b0;
        w_drive = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_free) begin
                    if (r_clr_act)                   w_next = CLR_SETUP;
                    else if (r_rd_busy || w_rd_new)  w_next = RD;
                    else if (r_count != '0)          w_next = WR_SETUP;
                end
            end
            WR_SETUP, WR_HOLD: begin
                w_addr  = {w_head[21:12], 8'b0};
                w_wdata = {w_head[11:0], 4'b0};
                w_we_n  = (r_state != WR_SETUP);
                w_oe_n  = 1'b1;
                w_drive = 1'b1;
                w_next  = (r_state == WR_SETUP) ? WR_HOLD : IDLE;
            end
            RD: begin
                w_addr = {r_rd_x, r_rd_y, 8'b0};
                w_next = IDLE;
            end
            CLR_SETUP, CLR_HOLD: begin
                w_addr  = {r_cx, r_cy, 8'b0};
                w_we_n  = (r_state != CLR_SETUP);
                w_oe_n  = 1'b1;
                w_drive = 1'b1;
                w_next  = (r_state == CLR_SETUP) ? CLR_HOLD : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Pixel colour, one clock behind the beam; black outside the field
    always_ff @(posedge VGA_CTRL_CLK or negedge RST) begin
        if (!RST)       r_pix <= '0;
        else if (w_win) r_pix <= SRAM_DQ[15:4];
        else            r_pix <= '0;
    end

    assign SRAM_ADDR = w_addr;
    assign SRAM_DQ   = w_drive ? w_wdata : 16'bz;
    assign SRAM_WE_N = w_we_n;
    assign SRAM_OE_N = w_oe_n;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    assign pix_color    = r_pix;
    assign bus.wr_ready = w_wr_ready;
    assign bus.rd_busy  = r_rd_busy;
    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_color = r_rd_color;
    assign bus.clr_done = r_clr_done;
endmodule

// File: tb/tb_field_sram_port.sv
// Directed bench for field_sram_port with a behavioural async SRAM model.
module tb_field_sram_port;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  px, py;
    logic [11:0] pix_color;
    logic [17:0] addr;
    wire  [15:0] dq;
    logic        we_n, oe_n, ce_n, ub_n, lb_n;

    int nvec = 0;
    int nerr = 0;
    int wcnt = 0;   // SRAM writes seen
    int zcnt = 0;   // SRAM writes of colour 0
    logic [11:0] mem [1024] = '{default: 12'h800};

    field_sram_port_if bus ();

    field_sram_port dut (
        .VGA_CTRL_CLK (clk),
        .RST          (rst_n),
        .px           (px),
        .py           (py),
        .bus          (bus),
        .pix_color    (pix_color),
        .SRAM_ADDR    (addr),
        .SRAM_DQ      (dq),
        .SRAM_WE_N    (we_n),
        .SRAM_OE_N    (oe_n),
        .SRAM_CE_N    (ce_n),
        .SRAM_UB_N    (ub_n),
        .SRAM_LB_N    (lb_n)
    );

    always #5 clk = ~clk;

    // SRAM model: drives on read, latches while WE_N is low (sampled mid-cycle)
    assign dq = (!oe_n && we_n) ? {mem[addr[17:8]], 4'b0} : 16'bz;
    always @(negedge clk) begin
        if (!we_n) begin
            mem[addr[17:8]] <= dq[15:4];
            wcnt <= wcnt + 1;
            if (dq[15:4] == 12'h0) zcnt <= zcnt + 1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic do_read(input logic [4:0] x, input logic [4:0] y, input logic [11:0] exp, input string tag);
        int n;
        bus.rd_req = 1'b1; bus.rd_x = x; bus.rd_y = y;
        tick();
        bus.rd_req = 1'b0;
        n = 0;
        while (!bus.rd_valid && n < 20) begin tick(); n++; end
        chk({tag, "_valid"}, {31'b0, bus.rd_valid}, 32'h1);
        chk({tag, "_color"}, {20'b0, bus.rd_color}, {20'b0, exp});
    endtask

    initial begin
        int w0, z0, n, pulses, wc_at_done;
        rst_n = 1'b0; px = '0; py = '0;
        bus.wr_valid = 0; bus.wr_x = '0; bus.wr_y = '0; bus.wr_color = '0;
        bus.rd_req = 0; bus.rd_x = '0; bus.rd_y = '0; bus.clr_start = 0;
        tick(2);
        // reset state
        chk("rst_wr_ready", {31'b0, bus.wr_ready}, 32'h1);
        chk("rst_rd_busy",  {31'b0, bus.rd_busy},  32'h0);
        chk("rst_rd_valid", {31'b0, bus.rd_valid}, 32'h0);
        chk("rst_rd_color", {20'b0, bus.rd_color}, 32'h0);
        chk("rst_clr_done", {31'b0, bus.clr_done}, 32'h0);
        chk("rst_pix",      {20'b0, pix_color},    32'h0);
        chk("rst_strobes",  {27'b0, we_n, oe_n, ce_n, ub_n, lb_n}, 32'h10);
        chk("rst_dq_model", {16'b0, dq}, 32'h8000);
        rst_n = 1'b1;

        // fill FIFO inside the window, start a write, reset mid-write
        px = 10'd300; py = 10'd30;
        for (int k = 0; k < 4; k++) begin
            bus.wr_valid = 1; bus.wr_x = 5'(k); bus.wr_y = 5'd9; bus.wr_color = 12'hF00;
            tick();
        end
        bus.wr_valid = 0;
        chk("full_ready", {31'b0, bus.wr_ready}, 32'h0);
        px = 10'd0; py = 10'd0;
        w0 = wcnt;
        tick();
        chk("pre_rst_we", {31'b0, we_n}, 32'h0);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_we",    {31'b0, we_n},         32'h1);
        chk("async_rst_ready", {31'b0, bus.wr_ready}, 32'h1);
        chk("async_rst_pix",   {20'b0, pix_color},    32'h0);
        tick();
        rst_n = 1'b1;
        tick(6);
        chk("no_write_after_rst", wcnt - w0, 32'h0);

        // single write in a free slot, then see it on the beam
        px = 10'd300; py = 10'd30;
        tick();
        chk("pix_before_wr", {20'b0, pix_color}, 32'h800);
        px = 10'd0; py = 10'd0;
        w0 = wcnt;
        bus.wr_valid = 1; bus.wr_x = 5'd4; bus.wr_y = 5'd0; bus.wr_color = 12'h0FF;
        tick();
        bus.wr_valid = 0;
        tick();
        chk("wr_setup_we",   {31'b0, we_n},   32'h0);
        chk("wr_setup_addr", {14'b0, addr},   32'h08000);
        chk("wr_setup_dq",   {16'b0, dq},     32'h0FF0);
        tick();
        chk("wr_hold_we",    {31'b0, we_n},   32'h1);
        chk("wr_hold_addr",  {14'b0, addr},   32'h08000);
        tick();
        chk("wr_one_pulse",  wcnt - w0, 32'h1);
        px = 10'd300; py = 10'd30;
        tick();
        chk("pix_after_wr", {20'b0, pix_color}, 32'h0FF);

        // guard columns just before the window block a start
        px = 10'd218; py = 10'd30;
        w0 = wcnt;
        bus.wr_valid = 1; bus.wr_x = 5'd9; bus.wr_y = 5'd21; bus.wr_color = 12'h123;
        tick();
        bus.wr_valid = 0;
        tick(3);
        chk("guard218_we", {31'b0, we_n}, 32'h1);
        px = 10'd219;
        tick(2);
        chk("guard219_we", {31'b0, we_n}, 32'h1);
        chk("guard_no_wr", wcnt - w0, 32'h0);
        px = 10'd420;
        tick();
        chk("px420_we",   {31'b0, we_n}, 32'h0);
        chk("px420_addr", {14'b0, addr}, 32'h13500);
        chk("px420_dq",   {16'b0, dq},   32'h1230);
        tick(2);
        // window edges
        px = 10'd419; py = 10'd459;
        tick();
        chk("pix_corner", {20'b0, pix_color}, 32'h123);
        px = 10'd420;
        tick();
        chk("pix_right_out", {20'b0, pix_color}, 32'h0);
        px = 10'd220; py = 10'd20;
        tick();
        chk("pix_first", {20'b0, pix_color}, 32'h800);
        px = 10'd219;
        tick();
        chk("pix_left_out", {20'b0, pix_color}, 32'h0);

        // five writes during the window with a 4-deep FIFO
        px = 10'd300; py = 10'd30;
        w0 = wcnt;
        for (int k = 0; k < 4; k++) begin
            bus.wr_valid = 1; bus.wr_x = 5'(k); bus.wr_y = 5'd2; bus.wr_color = 12'(12'h100 + k);
            tick();
            chk($sformatf("bb_ready%0d", k), {31'b0, bus.wr_ready}, (k < 3) ? 32'h1 : 32'h0);
        end
        bus.wr_x = 5'd4; bus.wr_y = 5'd2; bus.wr_color = 12'h104;
        tick(3);
        chk("bb_still_full", {31'b0, bus.wr_ready}, 32'h0);
        px = 10'd0; py = 10'd0;
        n = 0;
        while (!bus.wr_ready && n < 20) begin tick(); n++; end
        chk("bb_ready_after_pop", {31'b0, bus.wr_ready}, 32'h1);
        tick();
        bus.wr_valid = 0;
        n = 0;
        while (wcnt - w0 < 5 && n < 100) begin tick(); n++; end
        tick(3);
        chk("bb_write_count", wcnt - w0, 32'h5);
        for (int k = 0; k < 5; k++)
            do_read(5'(k), 5'd2, 12'(12'h100 + k), $sformatf("bb_rd%0d", k));
        tick(2);

        // read and pending write in the same free cycle: read wins
        px = 10'd300; py = 10'd30;
        bus.wr_valid = 1; bus.wr_x = 5'd7; bus.wr_y = 5'd3; bus.wr_color = 12'hABC;
        tick();
        bus.wr_valid = 0;
        px = 10'd0; py = 10'd0;
        bus.rd_req = 1; bus.rd_x = 5'd7; bus.rd_y = 5'd3;
        tick();
        bus.rd_req = 0;
        chk("rdfirst_we",    {31'b0, we_n},         32'h1);
        chk("rdfirst_addr",  {14'b0, addr},         32'h0E300);
        chk("rdfirst_busy",  {31'b0, bus.rd_busy},  32'h1);
        chk("rdfirst_nvld",  {31'b0, bus.rd_valid}, 32'h0);
        tick();
        chk("rdfirst_valid", {31'b0, bus.rd_valid}, 32'h1);
        chk("rdfirst_color", {20'b0, bus.rd_color}, 32'h800);
        chk("rdfirst_bclr",  {31'b0, bus.rd_busy},  32'h0);
        tick();
        chk("rdfirst_vld_pulse", {31'b0, bus.rd_valid}, 32'h0);
        chk("wr_after_rd_we", {31'b0, we_n}, 32'h0);
        chk("wr_after_rd_dq", {16'b0, dq},   32'hABC0);
        tick(3);
        do_read(5'd7, 5'd3, 12'hABC, "rd_after_wr");
        tick(2);

        // whole-field clear with a queued write and a second clr_start
        w0 = wcnt; z0 = zcnt; pulses = 0; wc_at_done = -1;
        bus.wr_x = 5'd0; bus.wr_y = 5'd0; bus.wr_color = 12'h777;
        bus.clr_start = 1;
        tick();
        bus.clr_start = 0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (bus.clr_done) begin pulses++; wc_at_done = wcnt - w0; break; end
            bus.wr_valid  = (i == 10);
            bus.clr_start = (i == 300);
        end
        bus.wr_valid = 0; bus.clr_start = 0;
        chk("clr_done_seen", pulses, 32'h1);
        chk("clr_writes_at_done", wc_at_done, 32'd220);
        tick();
        chk("clr_done_pulse", {31'b0, bus.clr_done}, 32'h0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.clr_done) pulses++;
        end
        chk("clr_done_once",  pulses,      32'h1);
        chk("clr_zero_writes", zcnt - z0,  32'd220);
        chk("clr_then_fifo",  wcnt - w0,   32'd221);
        do_read(5'd9, 5'd21, 12'h000, "clr_rd_9_21");
        do_read(5'd3, 5'd2,  12'h000, "clr_rd_3_2");
        do_read(5'd0, 5'd0,  12'h777, "clr_rd_fifo");
        px = 10'd300; py = 10'd30;
        tick();
        chk("clr_pix", {20'b0, pix_color}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
